// File: rtl/wbuf_read_responder.sv
// Write buffer holding 32 x 128-bit entries keyed by {channel, id[2:0]}.
// Reads consume an entry and return its data through a single skid-free output register.
module wbuf_read_responder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         xbar_wbuf_wr_valid_i,
    output logic         xbar_wbuf_wr_ready_o,
    input  logic [1:0]   xbar_wbuf_wr_channel_id_i,
    input  logic [7:0]   xbar_wbuf_wr_wbuffer_id_i,
    input  logic [127:0] xbar_wbuf_wr_data_i,
    input  logic         rc_wbuf_req_valid_i,
    output logic         rc_wbuf_req_ready_o,
    input  logic [1:0]   rc_wbuf_req_channel_id_i,
    input  logic [7:0]   rc_wbuf_req_wbuffer_id_i,
    output logic         rc_wbuf_rtn_valid_o,
    input  logic         rc_wbuf_rtn_ready_i,
    output logic [127:0] rc_wbuf_rtn_data_o,
    output logic         wbuf_rd_err_o,
    output logic [5:0]   wbuf_free_cnt_o
);

    localparam int unsigned ENTRIES = 32;
    localparam int unsigned DW      = 128;

    logic [DW-1:0] mem [ENTRIES];
    logic [DW-1:0] rdata_q;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic               rtn_valid_q, rtn_valid_d;
    logic               zero_q, zero_d;
    logic               err_q, err_d;
    logic [5:0]         free_q, free_d;

    logic [4:0] wr_idx, rd_idx;
    logic       wr_legal, rd_legal;
    logic       wr_fire, rd_fire, rd_ok;

    assign wr_idx   = {xbar_wbuf_wr_channel_id_i, xbar_wbuf_wr_wbuffer_id_i[2:0]};
    assign rd_idx   = {rc_wbuf_req_channel_id_i, rc_wbuf_req_wbuffer_id_i[2:0]};
    assign wr_legal = (xbar_wbuf_wr_wbuffer_id_i[7:3] == 5'd0);
    assign rd_legal = (rc_wbuf_req_wbuffer_id_i[7:3] == 5'd0);

    // Illegal ids are always accepted so they drain, but never touch state.
    assign xbar_wbuf_wr_ready_o = !wr_legal || !valid_q[wr_idx];
    assign wr_fire              = xbar_wbuf_wr_valid_i && wr_legal && !valid_q[wr_idx];

    assign rc_wbuf_req_ready_o  = !rtn_valid_q || rc_wbuf_rtn_ready_i;
    assign rd_fire              = rc_wbuf_req_valid_i && rc_wbuf_req_ready_o;
    assign rd_ok                = rd_fire && rd_legal && valid_q[rd_idx];

    always_comb begin
        valid_d = valid_q;
        if (rd_ok) begin
            valid_d[rd_idx] = 1'b0;
        end
        if (wr_fire) begin
            valid_d[wr_idx] = 1'b1;
        end

        rtn_valid_d = rtn_valid_q;
        zero_d      = zero_q;
        if (rd_fire) begin
            rtn_valid_d = 1'b1;
            zero_d      = !rd_ok;
        end else if (rc_wbuf_rtn_ready_i) begin
            rtn_valid_d = 1'b0;
        end

        err_d  = rd_fire && !rd_ok;
        free_d = free_q + {5'd0, rd_ok} - {5'd0, wr_fire};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            rtn_valid_q <= 1'b0;
            zero_q      <= 1'b1;
            err_q       <= 1'b0;
            free_q      <= 6'd32;
        end else begin
            valid_q     <= valid_d;
            rtn_valid_q <= rtn_valid_d;
            zero_q      <= zero_d;
            err_q       <= err_d;
            free_q      <= free_d;
        end
    end

    // Storage and its read register carry no reset; zero_q masks stale data instead.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_idx] <= xbar_wbuf_wr_data_i;
        end
        if (rd_ok) begin
            rdata_q <= mem[rd_idx];
        end
    end

    assign rc_wbuf_rtn_valid_o = rtn_valid_q;
    assign rc_wbuf_rtn_data_o  = zero_q ? '0 : rdata_q;
    assign wbuf_rd_err_o       = err_q;
    assign wbuf_free_cnt_o     = free_q;

endmodule

// File: tb/tb_wbuf_read_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against an
// entry-array / response reference model.
module tb_wbuf_read_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr_valid;
    logic         wr_ready;
    logic [1:0]   wr_ch;
    logic [7:0]   wr_id;
    logic [127:0] wr_data;
    logic         req_valid;
    logic         req_ready;
    logic [1:0]   req_ch;
    logic [7:0]   req_id;
    logic         rtn_valid;
    logic         rtn_ready;
    logic [127:0] rtn_data;
    logic         rd_err;
    logic [5:0]   free_cnt;

    always #5 clk = ~clk;

    wbuf_read_responder dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .xbar_wbuf_wr_valid_i      (wr_valid),
        .xbar_wbuf_wr_ready_o      (wr_ready),
        .xbar_wbuf_wr_channel_id_i (wr_ch),
        .xbar_wbuf_wr_wbuffer_id_i (wr_id),
        .xbar_wbuf_wr_data_i       (wr_data),
        .rc_wbuf_req_valid_i       (req_valid),
        .rc_wbuf_req_ready_o       (req_ready),
        .rc_wbuf_req_channel_id_i  (req_ch),
        .rc_wbuf_req_wbuffer_id_i  (req_id),
        .rc_wbuf_rtn_valid_o       (rtn_valid),
        .rc_wbuf_rtn_ready_i       (rtn_ready),
        .rc_wbuf_rtn_data_o        (rtn_data),
        .wbuf_rd_err_o             (rd_err),
        .wbuf_free_cnt_o           (free_cnt)
    );

    // Reference model: entry contents, occupancy, and the response currently offered.
    logic [127:0] m_mem [32];
    logic [31:0]  m_valid;
    logic         m_rtn_valid;
    logic [127:0] m_rtn_data;
    logic         m_err;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid     = '0;
        m_rtn_valid = 1'b0;
        m_rtn_data  = '0;
        m_err       = 1'b0;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check readies, advance model.
    task automatic cyc(input logic wv, input logic [1:0] wch, input logic [7:0] wid,
                       input logic [127:0] wd, input logic rv, input logic [1:0] rch,
                       input logic [7:0] rid, input logic rr,
                       output logic wf, output logic rf);
        logic       exp_wr_ready, exp_req_ready;
        logic [4:0] widx, ridx;
        @(negedge clk);
        check_eq("rtn_valid", rtn_valid, m_rtn_valid);
        if (m_rtn_valid) check_eq("rtn_data", rtn_data, m_rtn_data);
        check_eq("rd_err", rd_err, m_err);
        check_eq("free_cnt", free_cnt, 128'(32 - $countones(m_valid)));
        wr_valid = wv; wr_ch = wch; wr_id = wid; wr_data = wd;
        req_valid = rv; req_ch = rch; req_id = rid; rtn_ready = rr;
        #1;
        widx = {wch, wid[2:0]};
        ridx = {rch, rid[2:0]};
        exp_wr_ready  = (wid[7:3] != 5'd0) || !m_valid[widx];
        exp_req_ready = !m_rtn_valid || rr;
        check_eq("wr_ready", wr_ready, exp_wr_ready);
        check_eq("req_ready", req_ready, exp_req_ready);
        wf = wv && exp_wr_ready;
        rf = rv && exp_req_ready;
        $display("cyc t=%0t wr=%0b ch%0d id%0h rd=%0b ch%0d id%0h rr=%0b free=%0d",
                 $time, wf, wch, wid, rf, rch, rid, rr, free_cnt);
        // Read sees pre-edge occupancy, then the write lands.
        m_err = 1'b0;
        if (rf) begin
            m_rtn_valid = 1'b1;
            if (rid[7:3] == 5'd0 && m_valid[ridx]) begin
                m_rtn_data     = m_mem[ridx];
                m_valid[ridx]  = 1'b0;
            end else begin
                m_rtn_data = '0;
                m_err      = 1'b1;
            end
        end else if (rr) begin
            m_rtn_valid = 1'b0;
        end
        if (wf && wid[7:3] == 5'd0) begin
            m_mem[widx]   = wd;
            m_valid[widx] = 1'b1;
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_rtn_valid", rtn_valid, 1'b0);
        check_eq("rst_rtn_data", rtn_data, 128'h0);
        check_eq("rst_rd_err", rd_err, 1'b0);
        check_eq("rst_free_cnt", free_cnt, 6'd32);
        check_eq("rst_req_ready", req_ready, 1'b1);
        check_eq("rst_wr_ready", wr_ready, 1'b1);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        wr_valid = 1'b0; req_valid = 1'b0; rtn_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        $display("reset asserted t=%0t", $time);
        check_reset_outputs();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic         wf, rf;
    logic [127:0] d;

    initial begin
        rst_n = 1'b0;
        wr_valid = 1'b0; wr_ch = '0; wr_id = '0; wr_data = '0;
        req_valid = 1'b0; req_ch = '0; req_id = '0; rtn_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // Write then read back one entry.
        cyc(1, 2'd1, 8'd5, {16{8'hA5}}, 0, 2'd0, 8'd0, 1, wf, rf);
        cyc(0, 2'd0, 8'd0, '0, 1, 2'd1, 8'd5, 1, wf, rf);
        repeat (2) cyc(0, 2'd0, 8'd0, '0, 0, 2'd0, 8'd0, 1, wf, rf);

        // Read of an empty entry.
        cyc(0, 2'd0, 8'd0, '0, 1, 2'd0, 8'd2, 1, wf, rf);
        repeat (2) cyc(0, 2'd0, 8'd0, '0, 0, 2'd0, 8'd0, 1, wf, rf);

        // Back-to-back writes to one entry stall until it is read.
        cyc(1, 2'd2, 8'd3, 128'h1111, 0, 2'd0, 8'd0, 1, wf, rf);
        cyc(1, 2'd2, 8'd3, 128'h2222, 0, 2'd0, 8'd0, 1, wf, rf);
        cyc(1, 2'd2, 8'd3, 128'h2222, 1, 2'd2, 8'd3, 1, wf, rf);
        cyc(1, 2'd2, 8'd3, 128'h2222, 0, 2'd0, 8'd0, 1, wf, rf);
        cyc(0, 2'd0, 8'd0, '0, 1, 2'd2, 8'd3, 1, wf, rf);
        cyc(0, 2'd0, 8'd0, '0, 0, 2'd0, 8'd0, 1, wf, rf);

        // Fill four entries, then read them with the return path stalled.
        for (int k = 0; k < 4; k++)
            cyc(1, 2'd3, 8'(k), {4{32'hC0DE_0000 + 32'(k)}}, 0, 2'd0, 8'd0, 1, wf, rf);
        begin
            int c = 0;
            for (int k = 0; k < 4; k++) begin
                int tries = 0;
                do begin
                    cyc(0, 2'd0, 8'd0, '0, 1, 2'd3, 8'(k), (c >= 5), wf, rf);
                    c++;
                    tries++;
                end while (!rf && tries < 20);
                check_eq("stall_read_fired", rf, 1'b1);
            end
        end
        repeat (2) cyc(0, 2'd0, 8'd0, '0, 0, 2'd0, 8'd0, 1, wf, rf);

        // Illegal ids on both ports.
        cyc(0, 2'd0, 8'd0, '0, 1, 2'd1, 8'h08, 1, wf, rf);
        cyc(1, 2'd1, 8'h10, 128'hDEAD, 0, 2'd0, 8'd0, 1, wf, rf);
        repeat (2) cyc(0, 2'd0, 8'd0, '0, 0, 2'd0, 8'd0, 1, wf, rf);

        // Reset with a pending response and three occupied entries.
        for (int k = 4; k < 7; k++)
            cyc(1, 2'd0, 8'(k), {8{16'hBEE0 + 16'(k)}}, 0, 2'd0, 8'd0, 0, wf, rf);
        cyc(0, 2'd0, 8'd0, '0, 1, 2'd0, 8'd4, 0, wf, rf);
        cyc(0, 2'd0, 8'd0, '0, 0, 2'd0, 8'd0, 0, wf, rf);
        mid_reset();
        cyc(0, 2'd0, 8'd0, '0, 0, 2'd0, 8'd0, 1, wf, rf);
        cyc(0, 2'd0, 8'd0, '0, 1, 2'd0, 8'd5, 1, wf, rf);
        repeat (2) cyc(0, 2'd0, 8'd0, '0, 0, 2'd0, 8'd0, 1, wf, rf);

        // Randomized traffic: narrow index set first for frequent hits, then full range.
        for (int phase = 0; phase < 2; phase++) begin
            for (int i = 0; i < 400; i++) begin
                logic [1:0] wch, rch;
                logic [7:0] wid, rid;
                wch = 2'($urandom_range(0, phase ? 3 : 1));
                rch = 2'($urandom_range(0, phase ? 3 : 1));
                wid = 8'($urandom_range(0, phase ? 7 : 3));
                rid = 8'($urandom_range(0, phase ? 7 : 3));
                if ($urandom_range(0, 15) == 0) wid[7:3] = 5'($urandom_range(1, 31));
                if ($urandom_range(0, 15) == 0) rid[7:3] = 5'($urandom_range(1, 31));
                d = {$urandom, $urandom, $urandom, $urandom};
                cyc(1'($urandom_range(0, 1)), wch, wid, d,
                    1'($urandom_range(0, 1)), rch, rid,
                    ($urandom_range(0, 3) != 0), wf, rf);
            end
            if (phase == 0) mid_reset();
        end
        repeat (2) cyc(0, 2'd0, 8'd0, '0, 0, 2'd0, 8'd0, 1, wf, rf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wbuf_read_responder.md
WBUF_READ_RESPONDER -- requirements
Module: wbuf_read_responder

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- xbar_wbuf_wr_valid_i  in  1  write-data beat valid.
- xbar_wbuf_wr_ready_o  out  1  write beat accepted.
- xbar_wbuf_wr_channel_id_i  in  2  writing channel.
- xbar_wbuf_wr_wbuffer_id_i  in  8  target entry id.
- xbar_wbuf_wr_data_i  in  128  write data.
- rc_wbuf_req_valid_i  in  1  read request from sram controller.
- rc_wbuf_req_ready_o  out  1  read request accepted.
- rc_wbuf_req_channel_id_i  in  2  requested channel.
- rc_wbuf_req_wbuffer_id_i  in  8  requested entry id.
- rc_wbuf_rtn_valid_o  out  1  return data valid.
- rc_wbuf_rtn_ready_i  in  1  sram controller takes return data.
- rc_wbuf_rtn_data_o  out  128  return data.
- wbuf_rd_err_o  out  1  one-cycle pulse on an erroneous read.
- wbuf_free_cnt_o  out  6  count of free entries, 0..32.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.

Function
REQ-003 SHALL hold 32 entries of 128 bits, each with a valid bit; entry index = {channel_id, wbuffer_id[2:0]}.
REQ-004 A wbuffer_id with bits [7:3] non-zero is illegal on either port.
REQ-005 Write fires when xbar_wbuf_wr_valid_i && xbar_wbuf_wr_ready_o; the entry's data is stored and its valid bit is set on that edge.
REQ-006 xbar_wbuf_wr_ready_o SHALL be low when the target entry is valid (back-pressure until it is freed), and high otherwise.
REQ-007 xbar_wbuf_wr_ready_o SHALL be high for an illegal id; that beat is dropped with no state change.
REQ-008 Read fires when rc_wbuf_req_valid_i && rc_wbuf_req_ready_o.
REQ-009 rc_wbuf_req_ready_o = !rc_wbuf_rtn_valid_o || rc_wbuf_rtn_ready_i (single output register, full throughput).
REQ-010 Latency: a read fired at edge N drives rc_wbuf_rtn_valid_o high from edge N+1 with the entry data.
REQ-011 The output register holds valid and data stable while rc_wbuf_rtn_ready_i is low.
REQ-012 A read of a valid legal entry returns its data and clears its valid bit on the firing edge.
REQ-013 A read of an invalid entry or illegal id still returns a response, with data 128'h0.
- wbuf_rd_err_o pulses high for exactly one cycle at N+1.
- No entry state changes.
REQ-014 Same-edge write fire and read fire to the same index:
- The read observes pre-edge state, so the entry must be invalid and the read takes the error path.
- The write completes normally.
REQ-015 Same-edge read fire and rtn handshake: the output register loads the new response; rtn_valid stays high.
REQ-016 wbuf_free_cnt_o = 32 minus the number of set valid bits, registered.
- Increments by 1 on a successful read, decrements by 1 on a write.
- Unchanged when both occur on the same edge.
REQ-017 Storage data array has no reset; valid bits, output register and counters do.

Reset
REQ-018 On rst_n low, asynchronously:
- all valid bits = 0;
- rc_wbuf_rtn_valid_o = 0, rc_wbuf_rtn_data_o = 0;
- wbuf_rd_err_o = 0;
- wbuf_free_cnt_o = 32.
REQ-019 After reset: rc_wbuf_req_ready_o = 1, and xbar_wbuf_wr_ready_o = 1 for any id.
REQ-020 Reset asserted mid-transfer discards the pending response and all buffered entries; no response is produced after deassertion.

Verification
REQ-021 Write ch1 id 5 data 0xA5..A5, then read ch1 id 5 with rtn_ready=1 -> rtn_valid one cycle after fire, data 0xA5..A5, free_cnt 32->31->32.
REQ-022 Read ch0 id 2 with no prior write -> rtn data 0, wbuf_rd_err_o one-cycle pulse, free_cnt stays 32.
REQ-023 Write ch2 id 3 twice back-to-back -> second beat stalled (wr_ready=0) until a read of ch2 id 3 fires, then accepted on the following cycle.
REQ-024 Fill 4 entries, issue 4 reads with rtn_ready low for 5 cycles -> first response held stable, req_ready=0, no reads lost; after release, 4 responses arrive in order on consecutive cycles.
REQ-025 Read with id 0x08 -> error response; write with id 0x10 -> accepted and dropped, free_cnt unchanged.
REQ-026 Assert rst_n low while rtn_valid=1 and 3 entries are valid -> outputs take reset values immediately; a subsequent read of a formerly valid entry returns the error response.
